// File: rtl/frame_capture_ctrl_if.sv
// Bundle of camera-side inputs, VGA frame marker, mode controls and the
// RAM write port / status outputs of frame_capture_ctrl.
// slave  : the capture controller itself.
// master : whatever drives the camera strobes and consumes the write port.
interface frame_capture_ctrl_if #(
  parameter int BANK_BITS = 19
);
  // camera front-end and control inputs
  logic                 cam_vsync_pulse;
  logic                 cam_pix_valid;
  logic [7:0]           cam_pix_data;
  logic                 vga_frame_end;
  logic                 mode_continuous;
  logic                 cmd_capture;
  // RAM write port and status outputs
  logic                 wr_en;
  logic [BANK_BITS:0]   wr_addr;
  logic [7:0]           wr_data;
  logic                 rd_bank;
  logic                 busy;
  logic                 overflow;
  logic [15:0]          frame_count;

  modport slave (
    input  cam_vsync_pulse, cam_pix_valid, cam_pix_data,
    input  vga_frame_end, mode_continuous, cmd_capture,
    output wr_en, wr_addr, wr_data, rd_bank, busy, overflow, frame_count
  );

  modport master (
    output cam_vsync_pulse, cam_pix_valid, cam_pix_data,
    output vga_frame_end, mode_continuous, cmd_capture,
    input  wr_en, wr_addr, wr_data, rd_bank, busy, overflow, frame_count
  );
endinterface

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: double-buffered camera capture sequencer.
// The camera fills bank bank_wr while the VGA reader scans rd_bank. A finished
// frame is handed to the reader only on vga_frame_end, so the screen never
// shows a half-written frame. RAM address = {bank, offset}.
// Optional feature macro: FRAME_CAPTURE_CTRL_FRAME_CNT_EN
//   defined   -> frame_count counts completed (swapped) frames, wraps at 16 bits
//   undefined -> frame_count is tied to 0 and no counter is built
module frame_capture_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BANK_BITS = 19
) (
  input  logic                 clk,
  input  logic                 reset_n,
  frame_capture_ctrl_if.slave  bus
);

  // Last valid offset inside one bank; writing there saturates the offset.
  localparam logic [BANK_BITS-1:0] LAST_OFFSET = BANK_BITS'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   bank_wr_q;
  logic                   rd_bank_q;
  logic [BANK_BITS-1:0]   offset_q;
  logic                   full_q;          // pixel at LAST_OFFSET already written
  logic                   swap_pending_q;
  logic                   wr_en_q;
  logic [BANK_BITS:0]     wr_addr_q;
  logic [7:0]             wr_data_q;
  logic                   busy_q;
  logic                   overflow_q;

  logic                   pix_accept;
  logic                   pix_overflow;
  logic                   swap_event;

  // Per-cycle events derived from the current state and inputs.
  always_comb begin
    pix_accept   = (state_q == CAPTURE) && bus.cam_pix_valid && !full_q;
    pix_overflow = (state_q == CAPTURE) && bus.cam_pix_valid &&  full_q;
    swap_event   = (state_q == DONE) && bus.vga_frame_end && swap_pending_q;
  end

  // Next-state selection; the vsync that ends a frame lands in DONE, so it can
  // never also start the next capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.mode_continuous || bus.cmd_capture) state_d = ARMED;
      ARMED:   if (bus.cam_vsync_pulse)                    state_d = CAPTURE;
      CAPTURE: if (bus.cam_vsync_pulse)                    state_d = DONE;
      DONE:    if (swap_event) state_d = bus.mode_continuous ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture sequencer: state, bank bookkeeping and registered write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      bank_wr_q      <= 1'b1;
      rd_bank_q      <= 1'b0;
      offset_q       <= '0;
      full_q         <= 1'b0;
      swap_pending_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ARMED) || (state_d == CAPTURE);
      wr_en_q <= pix_accept;

      // A pixel sharing its cycle with the closing vsync is still written here.
      if (pix_accept) begin
        wr_addr_q <= {bank_wr_q, offset_q};
        wr_data_q <= bus.cam_pix_data;
        if (offset_q == LAST_OFFSET) begin
          full_q <= 1'b1;
        end else begin
          offset_q <= offset_q + 1'b1;
        end
      end

      if (pix_overflow) begin
        overflow_q <= 1'b1;
      end

      case (state_q)
        ARMED: begin
          if (bus.cam_vsync_pulse) begin
            offset_q <= '0;
            full_q   <= 1'b0;
          end
        end
        CAPTURE: begin
          if (bus.cam_vsync_pulse) begin
            swap_pending_q <= 1'b1;
          end
        end
        DONE: begin
          if (swap_event) begin
            rd_bank_q      <= bank_wr_q;
            bank_wr_q      <= ~bank_wr_q;
            swap_pending_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_CAPTURE_CTRL_FRAME_CNT_EN
  logic [15:0] frame_count_q;

  // Count frames handed to the reader; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
    end else if (swap_event) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign bus.frame_count = frame_count_q;
`else
  assign bus.frame_count = 16'd0;
`endif

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_bank  = rd_bank_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Testbench for frame_capture_ctrl (H_ACTIVE=8, V_ACTIVE=4).
// Drives randomized camera frames and compares every RAM write and the
// bank/status outputs against a frame-level reference model.
module tb_frame_capture_ctrl;
  localparam int H    = 8;
  localparam int V    = 4;
  localparam int BB   = 19;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  frame_capture_ctrl_if #(.BANK_BITS(BB)) bus ();

  frame_capture_ctrl #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .BANK_BITS(BB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [BB:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t act_q[$];
  wr_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: which bank is shown / filled next, frames shown, overflow
  bit m_rd_bank = 1'b0;
  bit m_bank_wr = 1'b1;
  int m_frames  = 0;
  bit m_ovf     = 1'b0;
  bit m_armed   = 1'b0;
  bit mode_v    = 1'b0;

  // Every write seen on the RAM port, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) act_q.push_back({bus.wr_addr, bus.wr_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_fc();
`ifdef FRAME_CAPTURE_CTRL_FRAME_CNT_EN
    return 32'(m_frames & 32'hFFFF);
`else
    return 32'd0;
`endif
  endfunction

  task automatic set_mode(input bit m);
    mode_v = m;
    bus.mode_continuous = m;
  endtask

  // One clock of stimulus; strobes are held for exactly this cycle.
  task automatic step(input int vs, input int pv, input int d, input int vfe, input int cmd);
    bus.cam_vsync_pulse = vs[0];
    bus.cam_pix_valid   = pv[0];
    bus.cam_pix_data    = d[7:0];
    bus.vga_frame_end   = vfe[0];
    bus.cmd_capture     = cmd[0];
    @(posedge clk);
    #1;
    bus.cam_vsync_pulse = 1'b0;
    bus.cam_pix_valid   = 1'b0;
    bus.vga_frame_end   = 1'b0;
    bus.cmd_capture     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic arm();
    if (!m_armed) begin
      if (mode_v) step(0, 0, 0, 0, 0);
      else        step(0, 0, 0, 0, 1);
      m_armed = 1'b1;
    end
  endtask

  task automatic compare_writes(input string tag);
    check_eq({tag, "_nwrites"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check_eq({tag, "_write"}, 32'(act_q[i]), 32'(exp_q[i]));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic swap_vfe(input string tag);
    step(0, 0, 0, 1, 0);
    m_rd_bank = m_bank_wr;
    m_bank_wr = ~m_bank_wr;
    m_frames++;
    m_armed = mode_v;
    check_eq({tag, "_rd_bank"}, 32'(bus.rd_bank), 32'(m_rd_bank));
    check_eq({tag, "_frame_count"}, 32'(bus.frame_count), exp_fc());
    check_eq({tag, "_busy_after"}, 32'(bus.busy), 32'(mode_v));
  endtask

  // One camera frame starting from the armed state.
  task automatic capture_frame(input int npix, input bit seq_data, input bit vs_last,
                               input bit clear_mode, input bit do_vfe, input string tag);
    int d;
    // ignored while armed: pixels, stray vga_frame_end, cmd_capture
    repeat ($urandom_range(0, 3))
      step(0, 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    check_eq({tag, "_busy_armed"}, 32'(bus.busy), 32'd1);
    step(1, 0, 0, 0, 0);
    if (clear_mode) set_mode(1'b0);
    for (int k = 0; k < npix; k++) begin
      d = seq_data ? (k & 255) : int'($urandom_range(0, 255));
      if (k < NPIX) exp_q.push_back({m_bank_wr, BB'(k), 8'(d)});
      else          m_ovf = 1'b1;
      if (vs_last && k == npix - 1) begin
        step(1, 1, d, 0, 0);
      end else begin
        step(0, 1, d, 0, 0);
        repeat ($urandom_range(0, 2)) step(0, 0, int'($urandom_range(0, 255)), 0, 0);
      end
    end
    if (!(vs_last && npix > 0)) step(1, 0, 0, 0, 0);
    idle(1);
    check_eq({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_rd_bank_held"}, 32'(bus.rd_bank), 32'(m_rd_bank));
    check_eq({tag, "_overflow"}, 32'(bus.overflow), 32'(m_ovf));
    // while waiting for the VGA: new vsync/pixels/cmd must not start a capture
    repeat ($urandom_range(0, 3))
      step(int'($urandom_range(0, 1)), 1, int'($urandom_range(0, 255)), 0, int'($urandom_range(0, 1)));
    idle(1);
    compare_writes(tag);
    if (do_vfe) swap_vfe(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int np;
    bit cm;
    bus.cam_vsync_pulse = 1'b0;
    bus.cam_pix_valid   = 1'b0;
    bus.cam_pix_data    = 8'd0;
    bus.vga_frame_end   = 1'b0;
    bus.cmd_capture     = 1'b0;
    set_mode(1'b0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wr_en",    32'(bus.wr_en),       32'd0);
    check_eq("rst_wr_addr",  32'(bus.wr_addr),     32'd0);
    check_eq("rst_wr_data",  32'(bus.wr_data),     32'd0);
    check_eq("rst_rd_bank",  32'(bus.rd_bank),     32'd0);
    check_eq("rst_busy",     32'(bus.busy),        32'd0);
    check_eq("rst_overflow", 32'(bus.overflow),    32'd0);
    check_eq("rst_fcount",   32'(bus.frame_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // IDLE ignores everything but mode/cmd
    repeat (20)
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1)), 0);
    idle(1);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
    check_eq("idle_nwrites", 32'(act_q.size()), 32'd0);
    check_eq("idle_rd_bank", 32'(bus.rd_bank), 32'd0);
    act_q.delete();

    // single-shot: 32 pixels with data = offset, first bank is 1
    arm();
    capture_frame(NPIX, 1'b1, 1'b0, 1'b0, 1'b1, "single");

    // continuous: three frames, banks alternate
    set_mode(1'b1);
    for (int f = 0; f < 3; f++) begin
      arm();
      capture_frame(int'($urandom_range(1, NPIX)), 1'b0, 1'b0, 1'b0, 1'b1, "cont");
    end

    // overflow: 34 pixels, only 32 written
    arm();
    capture_frame(NPIX + 2, 1'b1, 1'b0, 1'b0, 1'b1, "ovf");

    // pixel together with vsync at offset 5, no VGA frame end for 1000 cycles
    arm();
    capture_frame(6, 1'b0, 1'b1, 1'b0, 1'b0, "samecyc");
    idle(1000);
    check_eq("samecyc_rd_bank_1000", 32'(bus.rd_bank), 32'(m_rd_bank));
    check_eq("samecyc_busy_1000", 32'(bus.busy), 32'd0);
    swap_vfe("samecyc");

    // randomized frames, modes and lengths (short, full, overflowing)
    for (int f = 0; f < 8; f++) begin
      set_mode(1'($urandom_range(0, 1)));
      arm();
      np = int'($urandom_range(0, NPIX + 4));
      cm = mode_v && ($urandom_range(0, 3) == 0);
      capture_frame(np, 1'b0, 1'($urandom_range(0, 1)), cm, 1'b1, "rand");
    end

    // reset in the middle of a capture at offset 10
    set_mode(1'b1);
    arm();
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back({m_bank_wr, BB'(k), 8'(k + 100)});
      step(0, 1, k + 100, 0, 0);
    end
    idle(1);
    compare_writes("prereset");
    bus.cam_pix_valid = 1'b1;
    bus.cam_pix_data  = 8'hA5;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_wr_en",    32'(bus.wr_en),       32'd0);
    check_eq("midrst_wr_addr",  32'(bus.wr_addr),     32'd0);
    check_eq("midrst_rd_bank",  32'(bus.rd_bank),     32'd0);
    check_eq("midrst_busy",     32'(bus.busy),        32'd0);
    check_eq("midrst_overflow", 32'(bus.overflow),    32'd0);
    check_eq("midrst_fcount",   32'(bus.frame_count), 32'd0);
    repeat (3) @(posedge clk);
    bus.cam_pix_valid = 1'b0;
    set_mode(1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    m_rd_bank = 1'b0;
    m_bank_wr = 1'b1;
    m_frames  = 0;
    m_ovf     = 1'b0;
    m_armed   = 1'b0;
    idle(2);
    check_eq("postrst_nwrites", 32'(act_q.size()), 32'd0);
    check_eq("postrst_busy", 32'(bus.busy), 32'd0);
    act_q.delete();
    arm();
    capture_frame(NPIX, 1'b0, 1'b0, 1'b0, 1'b1, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
Sequences camera pixels into the dual-port frame RAM and schedules which half of the RAM the VGA reader uses. It provides double buffering: the camera fills one bank while VGA scans the other. A finished frame is handed to the reader only at a VGA frame boundary, so the screen never shows a partially written frame. The block sits between the camera front-end and ram_2port, and drives the RAM write port and the upper bit of the VGA read address.

Parameters:
H_ACTIVE, 640, pixels per line
V_ACTIVE, 480, lines per frame
BANK_BITS, 19, offset width inside one bank; address = {bank, offset}

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous reset, active low
cam_vsync_pulse  in  1  one-cycle pulse at the start of each camera frame, synchronous to clk
cam_pix_valid  in  1  one-cycle strobe, pixel present on cam_pix_data
cam_pix_data  in  8  grey pixel
vga_frame_end  in  1  one-cycle pulse when VGA leaves its last active line
mode_continuous  in  1  1 = capture every frame; 0 = single-shot
cmd_capture  in  1  pulse that arms one single-shot capture
wr_en  out  1  RAM write enable
wr_addr  out  20  RAM write address {bank_wr, offset}
wr_data  out  8  RAM write data
rd_bank  out  1  bank the VGA reads; the VGA uses read_addr = {rd_bank, offset}
busy  out  1  high in ARMED or CAPTURE
overflow  out  1  sticky; a pixel arrived after offset reached H_ACTIVE*V_ACTIVE-1
frame_count  out  16  completed frames (see Optional Feature)

Behaviour:
- Reset values: all outputs 0. Internal state: state=IDLE, bank_wr=1, rd_bank=0, offset=0, swap_pending=0.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE:
  - mode_continuous=1 -> ARMED.
  - cmd_capture=1 -> ARMED.
  - All other input is ignored.
- ARMED:
  - Waits for cam_vsync_pulse, then clears offset and goes to CAPTURE.
  - Pixels arriving in ARMED are dropped.
- CAPTURE:
  - Each cam_pix_valid registers wr_en=1, wr_addr={bank_wr,offset}, wr_data=cam_pix_data. Latency is 1 cycle.
  - offset then increments.
  - When offset equals H_ACTIVE*V_ACTIVE-1 and a pixel is written, offset saturates.
  - Any further pixel in this frame is not written and sets overflow.
  - wr_en is low on every cycle without cam_pix_valid.
- End of frame: cam_vsync_pulse in CAPTURE -> DONE and swap_pending=1. This holds even when fewer pixels arrived (short frame); the stale tail is accepted.
- A pixel and cam_vsync_pulse on the same cycle: the pixel is written first, then the transition is taken.
- DONE:
  - On vga_frame_end with swap_pending=1: rd_bank<=bank_wr, bank_wr<=~bank_wr, swap_pending=0, frame_count+1.
  - Next state: ARMED if mode_continuous=1, else IDLE.
  - The cam_vsync_pulse that ended the frame does not start a new capture; the next frame is taken at the following vsync.
- vga_frame_end outside DONE has no effect.
- cmd_capture outside IDLE is ignored.
- Clearing mode_continuous while ARMED or CAPTURE: the current frame completes, then the block returns to IDLE.
- overflow clears only on reset.
- frame_count wraps 65535 -> 0.
- reset_n low at any time: immediate return to reset values. A partial frame is discarded and rd_bank stays at the last completed bank reset value 0.

Optional Feature:
FRAME_CAPTURE_CTRL_FRAME_CNT_EN
- Defined: frame_count counts as above.
- Undefined: frame_count is tied to 0 and the counter is not synthesised.

Test Plan:
(All scenarios use H_ACTIVE=8, V_ACTIVE=4.)
1. reset_n low, then release -> wr_en=0, rd_bank=0, busy=0, overflow=0; the first capture writes addresses 0x80000..0x8001F.
2. Single-shot: cmd_capture, vsync, 32 pixels 0..31, vsync, vga_frame_end -> 32 writes with data=offset; rd_bank=1; busy=0; frame_count=1.
3. Continuous: 3 frames with a vga_frame_end after each -> the banks written alternate 1,0,1; rd_bank follows 1,0,1; frame_count=3.
4. 34 pixels in one frame -> last write at offset 31, overflow=1, no write for pixels 33 and 34.
5. Pixel and vsync on the same cycle at offset 5 -> that pixel is written at offset 5 and the state becomes DONE; with no vga_frame_end, rd_bank is unchanged for 1000 cycles.
6. reset_n low mid-CAPTURE at offset 10 -> outputs return to reset values immediately; no write after the reset edge.
